// File: rtl/image_reader_pkg.sv
// Shared types and widths for the image memory read-side streamer.
// Legacy-compatible state encodings are exposed alongside the typed enum.
package image_reader_pkg;

   localparam int unsigned IMG_PIX_W = 8;
   localparam int unsigned IMG_ADR_W = 22;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      READ  = ST_READ,
      DRAIN = ST_DRAIN,
      DONE  = ST_DONE
   } rd_state_t;

endpackage

// File: rtl/pixel_skid_fifo.sv
// Small circular FIFO holding {last, pixel} words between the memory read port and the stream.
// Push and pop in the same cycle are both honoured, including when full.
module pixel_skid_fifo #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_pop  = pop && (count_q != '0);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;
   assign empty     = (count_q == '0);

endmodule

// File: rtl/image_stream_reader.sv
// Streams pix_count pixels from image memory starting at base_adr over valid/ready.
// Optional IMG_READER_CHECKSUM_EN adds a 16-bit running sum of accepted pixels.
module image_stream_reader
   import image_reader_pkg::*;
#(
   parameter int unsigned ADR_W = IMG_ADR_W,
   parameter int unsigned PIX_W = IMG_PIX_W,
   parameter int unsigned BUF_D = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [ADR_W-1:0] base_adr,
   input  logic [ADR_W-1:0] pix_count,
   output logic             busy,
   output logic             done,
   output logic             img_rd_en,
   output logic [ADR_W-1:0] img_adr,
   input  logic [PIX_W-1:0] img_rd_data,
   output logic [PIX_W-1:0] pix_data,
   output logic             pix_valid,
   input  logic             pix_ready,
   output logic             pix_last
`ifdef IMG_READER_CHECKSUM_EN
   ,
   output logic [15:0]      checksum
`endif
);

   localparam int unsigned CNT_W = $clog2(BUF_D + 1);
   localparam int unsigned OCC_W = CNT_W + 1;

   rd_state_t        state_q, state_d;
   logic [ADR_W-1:0] base_q, base_d;
   logic [ADR_W-1:0] count_q, count_d;
   logic [ADR_W-1:0] issued_q, issued_d;
   logic             in_flight_q, in_flight_d;
   logic             last_flight_q, last_flight_d;

   logic [CNT_W-1:0] fifo_count;
   logic             fifo_empty;
   logic [PIX_W:0]   fifo_head;
   logic             pix_pop;
   logic [OCC_W-1:0] occ;

   assign pix_pop = pix_valid && pix_ready;

   // Slots that will be committed after this edge: buffered + landing read - leaving pixel.
   assign occ = {1'b0, fifo_count} + OCC_W'(in_flight_q) - OCC_W'(pix_pop);

   assign img_rd_en = (state_q == READ) && (issued_q != count_q) && (occ < OCC_W'(BUF_D));
   assign img_adr   = base_q + issued_q;

   always_comb begin
      state_d       = state_q;
      base_d        = base_q;
      count_d       = count_q;
      issued_d      = issued_q;
      in_flight_d   = img_rd_en;
      last_flight_d = img_rd_en && (issued_q == count_q - ADR_W'(1));
      unique case (state_q)
         IDLE: begin
            if (start) begin
               base_d   = base_adr;
               count_d  = pix_count;
               issued_d = '0;
               state_d  = (pix_count == '0) ? DONE : READ;
            end
         end
         READ: begin
            if (img_rd_en) begin
               issued_d = issued_q + ADR_W'(1);
            end
            if (issued_d == count_q) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Looking at next-cycle occupancy lets done follow the last handshake directly.
            if ((occ == '0) && !in_flight_d) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= IDLE;
         base_q        <= '0;
         count_q       <= '0;
         issued_q      <= '0;
         in_flight_q   <= 1'b0;
         last_flight_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         base_q        <= base_d;
         count_q       <= count_d;
         issued_q      <= issued_d;
         in_flight_q   <= in_flight_d;
         last_flight_q <= last_flight_d;
      end
   end

   pixel_skid_fifo #(
      .WIDTH (PIX_W + 1),
      .DEPTH (BUF_D)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (in_flight_q),
      .push_data ({last_flight_q, img_rd_data}),
      .pop       (pix_pop),
      .head_data (fifo_head),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   assign pix_valid = !fifo_empty;
   assign pix_data  = pix_valid ? fifo_head[PIX_W-1:0] : '0;
   assign pix_last  = pix_valid && fifo_head[PIX_W];
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);

`ifdef IMG_READER_CHECKSUM_EN
   logic [15:0] checksum_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         checksum_q <= '0;
      end else if ((state_q == IDLE) && start) begin
         checksum_q <= '0;
      end else if (pix_pop) begin
         checksum_q <= checksum_q + 16'(pix_data);
      end
   end

   assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_image_stream_reader.sv
// Scoreboard bench for image_stream_reader; checksum checks need IMG_READER_CHECKSUM_EN.
module tb_image_stream_reader;

   localparam int FIRST_VALID_LAT = 3;  // start cycle -> first pix_valid cycle

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [21:0] base_adr;
   logic [21:0] pix_count;
   logic        busy;
   logic        done;
   logic        img_rd_en;
   logic [21:0] img_adr;
   logic [7:0]  img_rd_data = 8'h00;
   logic [7:0]  pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        pix_last;
`ifdef IMG_READER_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   image_stream_reader dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .base_adr    (base_adr),
      .pix_count   (pix_count),
      .busy        (busy),
      .done        (done),
      .img_rd_en   (img_rd_en),
      .img_adr     (img_adr),
      .img_rd_data (img_rd_data),
      .pix_data    (pix_data),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .pix_last    (pix_last)
`ifdef IMG_READER_CHECKSUM_EN
      ,
      .checksum    (checksum)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [8:0]  pix_q[$];
   logic [21:0] addr_q[$];
   logic [15:0] exp_sum;
   bit          mem_mode = 1'b0;
   bit          mon_en = 1'b0;
   bit          consec = 1'b0;
   bit          toggle = 1'b0;

   int   cyc = 0;
   int   start_cyc, last_ref, hs_frame, rd_frame, val_frame, busy_frame, done_cnt;
   int   out_cnt = 0;
   bit   first_seen, prev_stall, mon_hs;
   logic [8:0] prev_word;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] mem_fn(input logic [21:0] a);
      return mem_mode ? 8'hFF : a[7:0];
   endfunction

   // Synchronous-read image memory
   always @(posedge clk) begin
      if (img_rd_en) img_rd_data <= mem_fn(img_adr);
   end

   always @(negedge clk) begin
      cyc++;
      if (mon_en) begin
         mon_hs = pix_valid && pix_ready;
         if (start && !busy) begin
            start_cyc = cyc; last_ref = cyc; hs_frame = 0; rd_frame = 0;
            val_frame = 0; busy_frame = 0; done_cnt = 0; first_seen = 1'b0;
         end
         if (busy) busy_frame++;
         if (img_rd_en) begin
            rd_frame++;
            check("occupancy_le_buf", 32'((out_cnt + 1 - int'(mon_hs)) <= 2), 32'd1);
            if (addr_q.size() == 0) check("unexpected_read", 32'd1, 32'd0);
            else check("img_adr", 32'(img_adr), 32'(addr_q.pop_front()));
         end
         if (pix_valid) begin
            val_frame++;
            if (!first_seen) begin
               first_seen = 1'b1;
               check("first_valid_latency", 32'(cyc - start_cyc), 32'(FIRST_VALID_LAT));
            end
         end
         if (prev_stall) begin
            if (!pix_valid) check("valid_held", 32'd0, 32'd1);
            else check("stall_hold", 32'({pix_last, pix_data}), 32'(prev_word));
         end
         if (mon_hs) begin
            if (consec && hs_frame > 0) check("back_to_back", 32'(cyc - last_ref), 32'd1);
            if (pix_q.size() == 0) check("unexpected_pixel", 32'd1, 32'd0);
            else check("pixel", 32'({pix_last, pix_data}), 32'(pix_q.pop_front()));
            hs_frame++;
            last_ref = cyc;
         end
         if (done) begin
            done_cnt++;
            check("done_after_last", 32'(cyc - last_ref), 32'd1);
         end
         out_cnt += int'(img_rd_en) - int'(mon_hs);
         prev_stall = pix_valid && !pix_ready;
         prev_word  = {pix_last, pix_data};
      end
   end

   task automatic start_frame(input logic [21:0] b, input logic [21:0] n);
      logic [21:0] a;
      @(posedge clk); #1;
      base_adr  = b;
      pix_count = n;
      start     = 1'b1;
      exp_sum   = '0;
      for (int i = 0; i < int'(n); i++) begin
         a = b + 22'(i);
         addr_q.push_back(a);
         pix_q.push_back({(i == int'(n) - 1), mem_fn(a)});
         exp_sum = exp_sum + 16'(mem_fn(a));
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (toggle) pix_ready = ~pix_ready;
         if (done_cnt > 0) break;
      end
      pix_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("done_once", 32'(done_cnt), 32'd1);
      check("busy_after_done", 32'(busy), 32'd0);
      check("pix_q_empty", 32'(pix_q.size()), 32'd0);
      check("addr_q_empty", 32'(addr_q.size()), 32'd0);
`ifdef IMG_READER_CHECKSUM_EN
      check("checksum", 32'(checksum), 32'(exp_sum));
`endif
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; base_adr = '0; pix_count = '0; pix_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rd_en", 32'(img_rd_en), 32'd0);
      check("rst_valid", 32'(pix_valid), 32'd0);
      check("rst_adr", 32'(img_adr), 32'd0);
      @(posedge clk); #1;
      reset  = 1'b1;
      mon_en = 1'b1;

      // Streaming at full rate
      consec = 1'b1;
      start_frame(22'h100, 22'd4);
      wait_done(40);

      // Empty frame
      start_frame(22'h0, 22'd0);
      wait_done(10);
      check("zero_reads", 32'(rd_frame), 32'd0);
      check("zero_valid", 32'(val_frame), 32'd0);
      check("zero_busy_cycles", 32'(busy_frame), 32'd1);

      // Back-pressure with alternating ready
      consec = 1'b0;
      toggle = 1'b1;
      start_frame(22'h20, 22'd8);
      wait_done(80);
      toggle = 1'b0;

      // Address wrap
      consec = 1'b1;
      start_frame(22'h3FFFFE, 22'd4);
      wait_done(40);

      // Reset in the middle of a frame
      start_frame(22'h40, 22'd6);
      for (int i = 0; i < 50 && hs_frame < 3; i++) begin
         @(negedge clk); #1;
      end
      check("abort_reached", 32'(hs_frame), 32'd3);
      reset = 1'b0;
      @(posedge clk); #1;
      pix_q.delete();
      addr_q.delete();
      out_cnt = 0;
      prev_stall = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_valid", 32'(pix_valid), 32'd0);
      check("abort_rd_en", 32'(img_rd_en), 32'd0);
      check("abort_data", 32'({pix_last, pix_data}), 32'd0);
`ifdef IMG_READER_CHECKSUM_EN
      check("abort_checksum", 32'(checksum), 32'd0);
`endif
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("abort_no_done", 32'(done_cnt), 32'd0);
      start_frame(22'h80, 22'd2);
      wait_done(30);

`ifdef IMG_READER_CHECKSUM_EN
      mem_mode = 1'b1;
      start_frame(22'h0, 22'd258);
      wait_done(600);
      start_frame(22'h0, 22'd1);
      @(negedge clk);
      check("checksum_cleared", 32'(checksum), 32'd0);
      wait_done(30);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
